// File: rtl/aes_dec_serial.sv
// aes_dec_serial
//   Single-request AES decryption helper for the aes32dsi / aes32dsmi
//   instructions. One source byte is passed through the inverse S-box and,
//   for dsmi, through one column of InvMixColumns. The result is rotated
//   into byte lane bs and XORed into the accumulator.
//   The FSM steps IDLE -> CALC -> DONE. DONE holds the result until the
//   consumer takes it.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   valid_i, ready_o  request handshake from the execute stage
//   mix_i             1 = aes32dsmi, 0 = aes32dsi
//   bs_i              byte select within rs2_i
//   rs1_i, rs2_i      accumulator operand, source state column
//   kill_i            flush; abandons any in-flight operation
//   ready_i, valid_o  result handshake toward the ID stage
//   rd_o              result, forced to zero while valid_o is low
module aes_dec_serial #(
  parameter bit LOGIC_GATING = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        mix_i,
  input  logic [1:0]  bs_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        kill_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rd_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [31:0] rs1_q, rs1_d;
  logic [1:0]  bs_q, bs_d;
  logic        mix_q, mix_d;
  logic [31:0] rd_q, rd_d;

  logic        accept;
  logic        op_load;
  logic [7:0]  src_byte;
  logic [31:0] u;
  logic [31:0] u_rot;

  // GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  // Multiplicative inverse computed as a^254. The mapping 0 -> 0 falls out
  // naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box computed as the inverse affine map followed by GF
  // inversion. This replaces a 256-entry lookup table.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b;
    for (int unsigned i = 0; i < 8; i++) begin
      b[i] = y[(i + 2) % 8] ^ y[(i + 5) % 8] ^ y[(i + 7) % 8];
    end
    b = b ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Handshake and FSM.
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      IDLE:    ready_o = 1'b1;
      DONE: begin
        ready_o = ready_i;
        valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = valid_i && ready_o && !kill_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: state_d = DONE;
      DONE: if (ready_i) state_d = accept ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  // Operand capture.
  always_comb begin
    unique case (bs_i)
      2'd0: src_byte = rs2_i[7:0];
      2'd1: src_byte = rs2_i[15:8];
      2'd2: src_byte = rs2_i[23:16];
      default: src_byte = rs2_i[31:24];
    endcase
  end

  // Without gating the operand registers follow the inputs whenever the
  // unit is receptive. They still freeze during CALC, so the result
  // remains correct.
  assign op_load = LOGIC_GATING ? accept : ready_o;

  always_comb begin
    x_d   = x_q;
    rs1_d = rs1_q;
    bs_d  = bs_q;
    mix_d = mix_q;
    if (op_load) begin
      x_d   = inv_sbox(src_byte);
      rs1_d = rs1_i;
      bs_d  = bs_i;
      mix_d = mix_i;
    end
  end

  // Result computation.
  always_comb begin
    u = {24'h0, x_q};
    if (mix_q) begin
      u = {gf_mul(x_q, 8'h0B), gf_mul(x_q, 8'h0D),
           gf_mul(x_q, 8'h09), gf_mul(x_q, 8'h0E)};
    end
  end

  always_comb begin
    unique case (bs_q)
      2'd0: u_rot = u;
      2'd1: u_rot = {u[23:0], u[31:24]};
      2'd2: u_rot = {u[15:0], u[31:16]};
      default: u_rot = {u[7:0], u[31:8]};
    endcase
  end

  // rd must stay frozen in DONE. Outside DONE, an ungated build may load
  // it every cycle, because the output masking hides the value anyway.
  always_comb begin
    rd_d = rd_q;
    if (state_q == CALC || (!LOGIC_GATING && state_q != DONE)) begin
      rd_d = rs1_q ^ u_rot;
    end
  end

  assign rd_o = valid_o ? rd_q : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      x_q     <= '0;
      rs1_q   <= '0;
      bs_q    <= '0;
      mix_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rs1_q   <= rs1_d;
      bs_q    <= bs_d;
      mix_q   <= mix_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_aes_dec_serial.sv
module tb_aes_dec_serial;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic        mix_i;
  logic [1:0]  bs_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        kill_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] rd_o;

  int unsigned n_vec;
  int unsigned n_bad;

  aes_dec_serial #(.LOGIC_GATING(1'b1)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .mix_i   (mix_i),
    .bs_i    (bs_i),
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .kill_i  (kill_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .rd_o    (rd_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then wait 1 time unit so outputs settle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic mix, input logic [1:0] bs,
                       input logic [31:0] rs2, input logic [31:0] rs1);
    valid_i = 1'b1;
    mix_i   = mix;
    bs_i    = bs;
    rs2_i   = rs2;
    rs1_i   = rs1;
  endtask

  // Full transaction with ready_i high: accept, CALC, DONE, back to IDLE.
  task automatic run_op(input string tag, input logic mix, input logic [1:0] bs,
                        input logic [31:0] rs2, input logic [31:0] rs1,
                        input logic [31:0] exp);
    drive(mix, bs, rs2, rs1);
    ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk({tag, "_calc_valid"}, {31'h0, valid_o}, 32'h0);
    chk({tag, "_calc_ready"}, {31'h0, ready_o}, 32'h0);
    tick();
    chk({tag, "_done_valid"}, {31'h0, valid_o}, 32'h1);
    chk({tag, "_rd"}, rd_o, exp);
    tick();
    chk({tag, "_idle_valid"}, {31'h0, valid_o}, 32'h0);
    chk({tag, "_idle_rd"}, rd_o, 32'h0);
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    mix_i   = 1'b0;
    bs_i    = 2'd0;
    rs1_i   = '0;
    rs2_i   = '0;
    kill_i  = 1'b0;
    ready_i = 1'b1;
    #12;
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_ready", {31'h0, ready_o}, 32'h1);
    chk("rst_rd", rd_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed vectors. Expected values are derived from known S-box pairs:
    // S(52)=00, S(00)=63, S(01)=7C, S(53)=ED.
    run_op("dsi_zero",   1'b0, 2'd0, 32'h00000000, 32'h00000000, 32'h00000052);
    run_op("dsi_rot3",   1'b0, 2'd3, 32'h63000000, 32'h12345678, 32'h12345678);
    run_op("dsmi_ones",  1'b1, 2'd0, 32'h00000000, 32'hFFFFFFFF, 32'hAF580BAE);
    run_op("dsmi_zero",  1'b1, 2'd0, 32'h00000000, 32'h00000000, 32'h50A7F451);
    run_op("dsi_bs2",    1'b0, 2'd2, 32'h007C0000, 32'h00000000, 32'h00010000);
    run_op("dsmi_bs1",   1'b1, 2'd1, 32'h00007C00, 32'h00000000, 32'h0D090E0B);
    run_op("dsi_xor",    1'b0, 2'd0, 32'h000000ED, 32'hAAAAAAAA, 32'hAAAAAAF9);

    // Backpressure: the result is held in DONE, and a competing request is
    // ignored while ready_i is low.
    drive(1'b0, 2'd0, 32'h00000000, 32'h00000000);
    ready_i = 1'b0;
    tick();
    drive(1'b1, 2'd2, 32'h11111111, 32'h22222222);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", {31'h0, valid_o}, 32'h1);
      chk("bp_ready", {31'h0, ready_o}, 32'h0);
      chk("bp_rd", rd_o, 32'h00000052);
      tick();
    end
    drive(1'b1, 2'd0, 32'h00000000, 32'hFFFFFFFF);
    ready_i = 1'b1;
    #1;
    chk("b2b_ready", {31'h0, ready_o}, 32'h1);
    tick();
    valid_i = 1'b0;
    chk("b2b_calc_valid", {31'h0, valid_o}, 32'h0);
    tick();
    chk("b2b_valid", {31'h0, valid_o}, 32'h1);
    chk("b2b_rd", rd_o, 32'hAF580BAE);
    tick();
    chk("b2b_idle", {31'h0, valid_o}, 32'h0);

    // A kill in CALC drops the operation.
    drive(1'b0, 2'd0, 32'h00000000, 32'h00000000);
    tick();
    valid_i = 1'b0;
    kill_i  = 1'b1;
    tick();
    kill_i = 1'b0;
    chk("kill_calc_valid", {31'h0, valid_o}, 32'h0);
    chk("kill_calc_ready", {31'h0, ready_o}, 32'h1);
    tick();
    chk("kill_calc_later", {31'h0, valid_o}, 32'h0);

    // A kill together with valid_i in IDLE blocks acceptance.
    drive(1'b0, 2'd0, 32'h00000000, 32'h00000000);
    kill_i = 1'b1;
    tick();
    valid_i = 1'b0;
    kill_i  = 1'b0;
    chk("kill_idle_ready", {31'h0, ready_o}, 32'h1);
    tick();
    chk("kill_idle_valid", {31'h0, valid_o}, 32'h0);

    // An asynchronous reset in DONE clears the outputs before the next edge.
    drive(1'b1, 2'd0, 32'h00000000, 32'h00000000);
    ready_i = 1'b0;
    tick();
    valid_i = 1'b0;
    tick();
    chk("ar_pre_valid", {31'h0, valid_o}, 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_valid", {31'h0, valid_o}, 32'h0);
    chk("ar_rd", rd_o, 32'h0);
    chk("ar_ready", {31'h0, ready_o}, 32'h1);
    #2;
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    chk("ar_release_valid", {31'h0, valid_o}, 32'h0);
    // The first accept happens on the first edge after release.
    run_op("post_rst", 1'b0, 2'd1, 32'h00000000, 32'h0000FF00, 32'h0000AD00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
